// File: rtl/spi_reg_master.sv
// rtl/spi_reg_master.sv - SPI mode-0 frame transmitter for the raybox-zero register-load port
// One accepted {cmd,data} request becomes one MSB-first frame framed by /SS low.
module spi_reg_master #(
  parameter int CLK_DIV   = 4,
  parameter int SS_GAP    = 8,
  parameter int CMD_BITS  = 4,
  parameter int DATA_BITS = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_valid,
  input  logic [CMD_BITS-1:0]  i_cmd,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_ready,
  output logic                 o_done,
  output logic                 o_sclk,
  output logic                 o_ss_n,
  output logic                 o_mosi
);

  localparam int FRAME_BITS = CMD_BITS + DATA_BITS;
  localparam int BC_W       = $clog2(FRAME_BITS);
  localparam int CNT_MAX    = (CLK_DIV > SS_GAP) ? CLK_DIV : SS_GAP;
  localparam int CNT_W      = $clog2(CNT_MAX);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    HIGH,
    LOW,
    TRAIL,
    GAP
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [BC_W-1:0]         bit_cnt_q;
  logic [FRAME_BITS-1:0]   shift_q;
  logic                    ready_q;
  logic                    done_q;
  logic                    sclk_q;
  logic                    ss_n_q;
  logic                    mosi_q;

  // Every phase (LEAD, HIGH, LOW, TRAIL, GAP) runs cnt_q down to zero before leaving.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      ss_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            shift_q   <= {i_cmd, i_data};
            bit_cnt_q <= BC_W'(FRAME_BITS - 1);
            cnt_q     <= CNT_W'(CLK_DIV - 1);
            ss_n_q    <= 1'b0;
            mosi_q    <= i_cmd[CMD_BITS-1];
            ready_q   <= 1'b0;
            state_q   <= LEAD;
          end
        end
        LEAD, LOW: begin
          if (cnt_q == '0) begin
            cnt_q   <= CNT_W'(CLK_DIV - 1);
            sclk_q  <= 1'b1;
            state_q <= HIGH;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        HIGH: begin
          if (cnt_q == '0) begin
            cnt_q  <= CNT_W'(CLK_DIV - 1);
            sclk_q <= 1'b0;
            if (bit_cnt_q == '0) begin
              mosi_q  <= 1'b0;
              state_q <= TRAIL;
            end else begin
              // MOSI moves on the falling edge so it is settled a full half-period before the next rise.
              shift_q   <= shift_q << 1;
              mosi_q    <= shift_q[FRAME_BITS-2];
              bit_cnt_q <= bit_cnt_q - 1'b1;
              state_q   <= LOW;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        TRAIL: begin
          if (cnt_q == '0) begin
            cnt_q   <= CNT_W'(SS_GAP - 1);
            ss_n_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= GAP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          ready_q <= 1'b1;
          sclk_q  <= 1'b0;
          ss_n_q  <= 1'b1;
          mosi_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_done  = done_q;
  assign o_sclk  = sclk_q;
  assign o_ss_n  = ss_n_q;
  assign o_mosi  = mosi_q;

endmodule

// File: tb/tb_spi_reg_master.sv
// tb/tb_spi_reg_master.sv - self-checking bench for spi_reg_master
// Two instances: defaults (index 0) and CLK_DIV=7/SS_GAP=1 (index 1), each with a receiver model.
module tb_spi_reg_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   [2];
  logic       valid [2];
  logic [3:0] cmd   [2];
  logic [5:0] data  [2];
  logic       ready [2];
  logic       done  [2];
  logic       sclk  [2];
  logic       ss_n  [2];
  logic       mosi  [2];

  spi_reg_master u_dut0 (
    .clk(clk), .reset(rst[0]), .i_valid(valid[0]), .i_cmd(cmd[0]), .i_data(data[0]),
    .o_ready(ready[0]), .o_done(done[0]), .o_sclk(sclk[0]), .o_ss_n(ss_n[0]), .o_mosi(mosi[0])
  );

  spi_reg_master #(.CLK_DIV(7), .SS_GAP(1)) u_dut1 (
    .clk(clk), .reset(rst[1]), .i_valid(valid[1]), .i_cmd(cmd[1]), .i_data(data[1]),
    .o_ready(ready[1]), .o_done(done[1]), .o_sclk(sclk[1]), .o_ss_n(ss_n[1]), .o_mosi(mosi[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Receiver / protocol monitor, sampled on the falling clk edge
  int         half_div  [2] = '{4, 7};
  logic       p_sclk    [2];
  logic       p_ss      [2];
  logic       p_mosi    [2];
  int         ph        [2];
  int         since     [2];
  int         ss_low    [2];
  int         last_low  [2];
  int         rx_n      [2];
  int         frames    [2];
  int         done_cnt  [2];
  int         acc_cnt   [2];
  int         acc_last  [2];
  int         acc_prev  [2];
  int         phase_err [2];
  int         mosi_err  [2];
  logic [9:0] rx        [2];
  logic [9:0] last_frame[2];
  logic [5:0] regs      [2][3];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (valid[d] && ready[d] && !rst[d]) begin
        acc_prev[d] = acc_last[d];
        acc_last[d] = cyc;
        acc_cnt[d]++;
      end
      if (done[d] === 1'b1) done_cnt[d]++;
      if (mosi[d] !== p_mosi[d]) begin
        if (sclk[d] === 1'b1) mosi_err[d]++;
        since[d] = 0;
      end else begin
        since[d]++;
      end
      if (ss_n[d] === 1'b0) begin
        if (p_ss[d] === 1'b1) begin
          ph[d] = 1; ss_low[d] = 1; rx_n[d] = 0; frames[d]++;
        end else begin
          ss_low[d]++;
          if (sclk[d] !== p_sclk[d]) begin
            if (ph[d] != half_div[d]) phase_err[d]++;
            ph[d] = 1;
            if (sclk[d] === 1'b1) begin
              if (since[d] < half_div[d]) mosi_err[d]++;
              rx[d] = {rx[d][8:0], mosi[d]};
              rx_n[d]++;
            end
          end else begin
            ph[d]++;
          end
        end
      end else begin
        if (p_ss[d] === 1'b0) begin
          last_low[d] = ss_low[d];
          if (rx_n[d] == 10) begin
            if (ph[d] != half_div[d]) phase_err[d]++;
            last_frame[d] = rx[d];
            if (rx[d][9:6] < 4'd3) regs[d][int'(rx[d][9:6])] = rx[d][5:0];
          end
        end
        rx_n[d] = 0;
      end
      p_sclk[d] = sclk[d];
      p_ss[d]   = ss_n[d];
      p_mosi[d] = mosi[d];
    end
  end

  task automatic send(input int d, input logic [3:0] c, input logic [5:0] v);
    int n = 0;
    @(posedge clk); #1;
    valid[d] = 1'b1; cmd[d] = c; data[d] = v;
    while (!ready[d] && n < 400) begin @(posedge clk); #1; n++; end
    check("send_ready", ready[d], 1);
    @(posedge clk); #1;
    valid[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int target);
    int n = 0;
    while (done_cnt[d] < target && n < 600) begin @(posedge clk); n++; end
    check("done_seen", done_cnt[d] >= target, 1);
  endtask

  // Back-to-back pair with i_valid held high; returns accept-to-accept period
  task automatic pair(input int d, input logic [3:0] c1, input logic [5:0] v1,
                      input logic [3:0] c2, input logic [5:0] v2, output int period);
    int n = 0;
    int ac;
    @(posedge clk); #1;
    while (!ready[d] && n < 400) begin @(posedge clk); #1; n++; end
    ac = acc_cnt[d];
    valid[d] = 1'b1; cmd[d] = c1; data[d] = v1;
    @(posedge clk); #1;
    cmd[d] = c2; data[d] = v2;
    n = 0;
    while (acc_cnt[d] < ac + 2 && n < 400) begin @(posedge clk); #1; n++; end
    valid[d] = 1'b0;
    check("pair_accepts", acc_cnt[d], ac + 2);
    period = acc_last[d] - acc_prev[d];
  endtask

  typedef struct {
    int         d;
    logic [3:0] c;
    logic [5:0] v;
    logic [9:0] exp_bits;
    int         exp_low;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int dc;
    int fr;
    int per;
    int n;

    vecs[0] = '{0, 4'd0, 6'b110011, 10'b0000110011, 84};
    vecs[1] = '{0, 4'd1, 6'b101010, 10'b0001101010, 84};
    vecs[2] = '{1, 4'd2, 6'b000111, 10'b0010000111, 147};
    vecs[3] = '{1, 4'd0, 6'b111111, 10'b0000111111, 147};
    vecs[4] = '{0, 4'd2, 6'b100001, 10'b0010100001, 84};

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; valid[d] = 1'b0; cmd[d] = '0; data[d] = '0;
      p_sclk[d] = 1'b0; p_ss[d] = 1'b1; p_mosi[d] = 1'b0;
      ph[d] = 0; since[d] = 100; ss_low[d] = 0; last_low[d] = 0; rx_n[d] = 0;
      frames[d] = 0; done_cnt[d] = 0; acc_cnt[d] = 0; acc_last[d] = 0; acc_prev[d] = 0;
      phase_err[d] = 0; mosi_err[d] = 0; rx[d] = '0; last_frame[d] = '0;
      for (int r = 0; r < 3; r++) regs[d][r] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_ss_n", ss_n[d], 1);
      check("rst_sclk", sclk[d], 0);
      check("rst_mosi", mosi[d], 0);
      check("rst_ready", ready[d], 1);
      check("rst_done", done[d], 0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;

    for (int i = 0; i < 5; i++) begin
      dc = done_cnt[vecs[i].d];
      send(vecs[i].d, vecs[i].c, vecs[i].v);
      wait_done(vecs[i].d, dc + 1);
      repeat (12) @(posedge clk);
      check("vec_bits", last_frame[vecs[i].d], vecs[i].exp_bits);
      check("vec_ss_low", last_low[vecs[i].d], vecs[i].exp_low);
      check("vec_reg", regs[vecs[i].d][int'(vecs[i].c)], vecs[i].v);
      check("vec_done_once", done_cnt[vecs[i].d], dc + 1);
    end

    dc = done_cnt[0];
    pair(0, 4'd1, 6'b101010, 4'd2, 6'b000111, per);
    check("b2b_period", per, 93);
    wait_done(0, dc + 2);
    repeat (12) @(posedge clk);
    check("b2b_floor", regs[0][1], 6'b101010);
    check("b2b_leak", regs[0][2], 6'b000111);

    dc = done_cnt[0];
    fr = frames[0];
    send(0, 4'd0, 6'b010101);
    repeat (19) @(posedge clk);
    #1;
    valid[0] = 1'b1; cmd[0] = 4'd0; data[0] = 6'h3F;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    wait_done(0, dc + 1);
    repeat (120) @(posedge clk);
    check("busy_frames", frames[0], fr + 1);
    check("busy_done", done_cnt[0], dc + 1);
    check("busy_sky", regs[0][0], 6'b010101);

    dc = done_cnt[0];
    send(0, 4'd0, 6'b111000);
    n = 0;
    while (rx_n[0] < 5 && n < 200) begin @(posedge clk); #1; n++; end
    check("abort_rises", rx_n[0], 5);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    check("abort_ss_n", ss_n[0], 1);
    check("abort_sclk", sclk[0], 0);
    check("abort_mosi", mosi[0], 0);
    check("abort_ready", ready[0], 1);
    check("abort_done", done[0], 0);
    rst[0] = 1'b0;
    repeat (30) @(posedge clk);
    check("abort_no_done", done_cnt[0], dc);
    check("abort_sky_kept", regs[0][0], 6'b010101);
    send(0, 4'd0, 6'b000001);
    wait_done(0, dc + 1);
    repeat (12) @(posedge clk);
    check("after_abort_sky", regs[0][0], 6'b000001);
    check("after_abort_bits", last_frame[0], 10'b0000000001);

    dc = done_cnt[1];
    pair(1, 4'd1, 6'b001100, 4'd2, 6'b110000, per);
    check("div7_period", per, 149);
    wait_done(1, dc + 2);
    repeat (12) @(posedge clk);
    check("div7_ss_low", last_low[1], 147);
    check("div7_floor", regs[1][1], 6'b001100);
    check("div7_leak", regs[1][2], 6'b110000);

    for (int d = 0; d < 2; d++) begin
      check("phase_len", phase_err[d], 0);
      check("mosi_stable", mosi_err[d], 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_reg_master.md
# spi_reg_master

SPI-mode-0 frame transmitter that drives the register-load SPI port of the raybox-zero core (SCLK, /SS, MOSI) from a simple valid/ready command interface. Each accepted request becomes one frame: a 4-bit command followed by 6 data bits, MSB-first, with /SS held low for the whole frame. The block is used in test harnesses and on-chip debug or bootstrap logic to set sky/floor/leak and later registers without an external MCU. SCLK is generated slowly enough for a receiver that runs on the same clock and uses 2-FF input synchronisers.

## Interface
Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period; legal range 4..255 (the receiver's synchroniser needs at least 3).
- SS_GAP, 8, clk cycles /SS stays high after a frame before the next can start; legal range ≥1.
- CMD_BITS, 4, command field width.
- DATA_BITS, 6, data field width.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- i_valid  in  1  request present.
- i_cmd  in  CMD_BITS  command (0=sky, 1=floor, 2=leak).
- i_data  in  DATA_BITS  payload.
- o_ready  out  1  block idle; a request is accepted on any clk edge where i_valid && o_ready.
- o_done  out  1  one-cycle pulse when a frame completes normally.
- o_sclk  out  1  SPI clock, idles low.
- o_ss_n  out  1  active-low slave select.
- o_mosi  out  1  serial data.

## Operation
- All outputs are registered. Reset values: o_ss_n=1, o_sclk=0, o_mosi=0, o_ready=1, o_done=0, state=IDLE.
- On acceptance, the block latches {i_cmd,i_data} into a FRAME_BITS=CMD_BITS+DATA_BITS shift register and loads bit_count=FRAME_BITS-1.
- States:
  - IDLE: ss_n=1, sclk=0, mosi=0, ready=1. On accept, go to LEAD.
  - LEAD: ss_n=0, sclk=0, mosi=frame MSB; lasts CLK_DIV cycles, then HIGH.
  - HIGH: sclk=1, mosi held; lasts CLK_DIV cycles. If bit_count==0, go to TRAIL. Otherwise shift left, decrement bit_count, and go to LOW.
  - LOW: sclk=0, mosi=new MSB (it changes on the cycle sclk falls); lasts CLK_DIV cycles, then HIGH.
  - TRAIL: ss_n=0, sclk=0, mosi=0; lasts CLK_DIV cycles, then GAP.
  - GAP: ss_n=1. o_done=1 on the first GAP cycle only. Lasts SS_GAP cycles, then IDLE.
- o_ready=0 in every state except IDLE. i_valid while busy is ignored, and no queueing is done.
- MOSI is stable for a full CLK_DIV on both sides of each SCLK rising edge.
- Reset mid-frame aborts the frame: next cycle ss_n=1, sclk=0, with no o_done pulse. The receiver discards the partial frame because its counter clears when /SS is inactive.
- If i_valid is held high through GAP, the next request is accepted on the first IDLE cycle.

## Timing
- Accept at edge T: o_ss_n falls and o_mosi=bit9 are visible from T+1.
- First SCLK rise at T+1+CLK_DIV.
- Bit k (k=0..FRAME_BITS-1, MSB first) rises at T+1+CLK_DIV*(1+2k).
- Last fall at T+1+CLK_DIV*2*FRAME_BITS.
- /SS low for (2*FRAME_BITS+1)*CLK_DIV cycles: 84 at defaults.
- o_done is asserted at T+1+84, the same cycle o_ss_n rises.
- o_ready rises at T+1+84+SS_GAP: 93 at defaults.
- Minimum accept-to-accept period: 1+84+SS_GAP cycles = 93 at defaults.
- bit_count width: clog2(FRAME_BITS). Divider counter width: clog2(max(CLK_DIV,SS_GAP)).

## Test plan
- Sky write: cmd=0, data=6'b110011, defaults.
  - MOSI sampled at the 10 SCLK rises is 0000110011.
  - /SS is low for exactly 84 cycles.
  - o_done pulses once.
  - A paired spi_registers instance, after load_new, holds sky=6'b110011.
- Floor then leak, back-to-back with i_valid held high: cmd=1/data=6'b101010, then cmd=2/data=6'b000111.
  - Second accept occurs exactly 93 cycles after the first.
  - Receiver shows floor=101010 and leak=000111.
- Busy ignore: pulse i_valid with cmd=0/data=6'h3F at T+20 of an active frame.
  - No extra frame is sent.
  - Exactly one o_done pulse.
- Reset mid-frame: assert reset after 5 SCLK rises.
  - Next cycle o_ss_n=1, o_sclk=0, o_mosi=0, o_ready=1, no o_done.
  - Receiver registers are unchanged.
  - A subsequent frame with cmd=0/data=6'b000001 loads sky=000001.
- CLK_DIV=7, SS_GAP=1:
  - Every SCLK high and low phase is 7 cycles.
  - /SS low for 147 cycles.
  - Accept-to-accept period is 149 cycles.
  - Receiver decodes correctly.
- MOSI stability check (all tests): o_mosi never toggles while o_sclk=1 or during the CLK_DIV cycles before each rise.
